// File: rtl/nes_mem_pkg.sv
// Shared NES memory-map constants, OAM DMA state encoding and page helper.
package nes_mem_pkg;

    localparam logic [15:0] PPU_OAMADDR = 16'h2003;
    localparam logic [15:0] PPU_OAMDATA = 16'h2004;
    localparam logic [15:0] PPU_ADDR    = 16'h2006;
    localparam logic [15:0] PPU_DATA    = 16'h2007;
    localparam logic [15:0] OAM_DMA     = 16'h4014;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } dma_state_t;

    // Pages $20-$40 map onto PPU/APU registers rather than RAM.
    function automatic logic page_is_io(input logic [7:0] page);
        return (page >= 8'h20) && (page <= 8'h40);
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA initiator: snoops $4014 writes, halts the CPU and copies one page to OAMDATA.
// Optional macro OAM_DMA_PAGE_GUARD_EN rejects triggers that target I/O pages.
module oam_dma_ctrl
    import nes_mem_pkg::*;
#(
    parameter int unsigned  XFER_LEN      = 256,
    parameter logic [15:0]  OAMDATA_ADDR  = PPU_OAMDATA,
    parameter logic [15:0]  DMA_TRIG_ADDR = OAM_DMA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_en,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic        dma_done,
    output logic        dma_err
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t  r_state;
    dma_state_t  w_next_state;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  w_next_page;
    logic [7:0]  w_next_idx;
    logic        r_parity;
    logic        w_trig;
    logic        w_accept;
    logic        r_cpu_halt;
    logic        r_dma_active;
    logic [15:0] r_mem_addr;
    logic        r_mem_write_en;
    logic        r_mem_read_en;
    logic        r_dma_done;

    assign w_trig = (r_state == IDLE) && cpu_write_en && (cpu_addr_in == DMA_TRIG_ADDR);

`ifdef OAM_DMA_PAGE_GUARD_EN
    logic w_reject;
    logic r_dma_err;

    assign w_reject = w_trig && page_is_io(cpu_data_in);
    assign w_accept = w_trig && !w_reject;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_dma_err <= 1'b0;
        else      r_dma_err <= w_reject;
    end

    assign dma_err = r_dma_err;
`else
    assign w_accept = w_trig;
    assign dma_err  = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = HALT;
            // r_parity is this cycle's parity, so the next cycle is even when it is 1
            HALT:    w_next_state = r_parity ? READ : ALIGN;
            ALIGN:   w_next_state = READ;
            READ:    w_next_state = WRITE;
            WRITE:   w_next_state = (r_idx == LAST_IDX) ? DONE : READ;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_next_page = r_page;
        w_next_idx  = r_idx;
        if (w_accept) begin
            w_next_page = cpu_data_in;
            w_next_idx  = '0;
        end else if (r_state == WRITE) begin
            w_next_idx = r_idx + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_page   <= '0;
            r_idx    <= '0;
            r_parity <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_page   <= w_next_page;
            r_idx    <= w_next_idx;
            r_parity <= ~r_parity;
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cpu_halt     <= 1'b0;
            r_dma_active   <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_write_en <= 1'b0;
            r_mem_read_en  <= 1'b0;
            r_dma_done     <= 1'b0;
        end else begin
            r_cpu_halt     <= w_next_state inside {HALT, ALIGN, READ, WRITE};
            r_dma_active   <= w_next_state inside {HALT, ALIGN, READ, WRITE};
            r_mem_read_en  <= (w_next_state == READ);
            r_mem_write_en <= (w_next_state == WRITE);
            r_dma_done     <= (w_next_state == DONE);
            if (w_next_state == READ)
                r_mem_addr <= {w_next_page, w_next_idx};
            else if (w_next_state == WRITE)
                r_mem_addr <= OAMDATA_ADDR;
            else
                r_mem_addr <= '0;
        end
    end

    assign cpu_halt     = r_cpu_halt;
    assign dma_active   = r_dma_active;
    assign mem_addr     = r_mem_addr;
    assign mem_write_en = r_mem_write_en;
    assign mem_read_en  = r_mem_read_en;
    assign dma_done     = r_dma_done;
    assign mem_data_out = (r_state == WRITE) ? mem_data_in : '0;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl with a behavioural CPU RAM / OAM model.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        cpu_write_en;
    logic [7:0]  mem_data_in;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;
    logic        mem_read_en;
    logic        dma_done;
    logic        dma_err;

    logic [7:0]  ram   [0:65535];
    logic [7:0]  spram [0:255];
    logic [7:0]  oamaddr;
    int unsigned cyc;
    int          checks;
    int          errors;

    oam_dma_ctrl #(
        .XFER_LEN      (256),
        .OAMDATA_ADDR  (16'h2004),
        .DMA_TRIG_ADDR (16'h4014)
    ) u_dut (
        .clk          (clk),
        .rst          (rst_n),
        .cpu_addr_in  (cpu_addr_in),
        .cpu_data_in  (cpu_data_in),
        .cpu_write_en (cpu_write_en),
        .mem_data_in  (mem_data_in),
        .cpu_halt     (cpu_halt),
        .dma_active   (dma_active),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .dma_done     (dma_done),
        .dma_err      (dma_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release; its LSB is the expected CPU-cycle parity.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // mem_ctrl stand-in: read data one cycle later, OAMDATA writes auto-increment OAMADDR.
    always @(posedge clk) begin
        if (mem_read_en) mem_data_in <= ram[mem_addr];
        if (mem_write_en && mem_addr == 16'h2004) begin
            spram[oamaddr] <= mem_data_out;
            oamaddr        <= oamaddr + 8'd1;
        end
        if (cpu_write_en && !dma_active && cpu_addr_in == 16'h2003)
            oamaddr <= cpu_data_in;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr_in  = a;
        cpu_data_in  = d;
        cpu_write_en = 1'b1;
        @(negedge clk);
        cpu_write_en = 1'b0;
        cpu_addr_in  = '0;
        cpu_data_in  = '0;
    endtask

    task automatic fill_random(input logic [7:0] page);
        for (int i = 0; i < 256; i++) ram[{page, 8'(i)}] = 8'($urandom);
    endtask

    // Full transfer: halt length from trigger parity, one done pulse, 256 bytes landing at OAMADDR+i.
    task automatic run_dma(input logic [7:0] page, input logic [7:0] oam0,
                           input bit want_par, input bit retrig);
        int  t_cyc;
        int  halt_cnt;
        int  done_cnt;
        int  wr_cnt;
        int  post;
        bit  seen;
        bit  rt_done;
        logic [7:0] idx;

        cpu_wr(16'h2003, oam0);
        @(negedge clk);
        if (cyc[0] != want_par) @(negedge clk);
        t_cyc        = cyc;
        cpu_addr_in  = 16'h4014;
        cpu_data_in  = page;
        cpu_write_en = 1'b1;
        @(negedge clk);
        cpu_write_en = 1'b0;
        cpu_addr_in  = '0;
        cpu_data_in  = '0;
        check_eq("halt_at_t1", cpu_halt, 1);
        check_eq("active_at_t1", dma_active, 1);

        halt_cnt = 0; done_cnt = 0; wr_cnt = 0; post = 0; seen = 0; rt_done = 0;
        for (int n = 0; n < 1200; n++) begin
            if (n > 0) @(negedge clk);
            if (cpu_write_en) begin
                cpu_write_en = 1'b0;
                cpu_addr_in  = '0;
                cpu_data_in  = '0;
            end
            halt_cnt += int'(cpu_halt);
            done_cnt += int'(dma_done);
            wr_cnt   += int'(mem_write_en);
            if (retrig && !rt_done && mem_write_en && wr_cnt == 50) begin
                cpu_addr_in  = 16'h4014;
                cpu_data_in  = page ^ 8'h01;
                cpu_write_en = 1'b1;
                rt_done      = 1;
            end
            if (dma_done) seen = 1;
            if (seen) begin
                post++;
                if (post > 4) break;
            end
        end
        check_eq("done_seen", seen, 1);
        check_eq("halt_cycles", halt_cnt, 513 + (t_cyc % 2));
        check_eq("done_pulses", done_cnt, 1);
        check_eq("write_count", wr_cnt, 256);
        check_eq("idle_after", cpu_halt, 0);
        for (int i = 0; i < 256; i++) begin
            idx = oam0 + 8'(i);
            check_eq("spram_byte", spram[idx], ram[{page, 8'(i)}]);
        end
    endtask

    initial begin
        logic [7:0] pg;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        cpu_addr_in = '0;
        cpu_data_in = '0;
        cpu_write_en = 1'b0;
        mem_data_in = '0;
        oamaddr = '0;
        for (int i = 0; i < 256; i++) spram[i] = '0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check_eq("rst_halt", cpu_halt, 0);
        check_eq("rst_active", dma_active, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_data", mem_data_out, 0);
        check_eq("rst_strobes", {mem_write_en, mem_read_en, dma_done, dma_err}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) ram[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;
        run_dma(8'h02, 8'h00, 1'b0, 1'b0);
        run_dma(8'h02, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 256; i++) ram[16'h0300 + 16'(i)] = 8'(i);
        run_dma(8'h03, 8'h10, 1'(($urandom)), 1'b0);
        check_eq("oam_off_10", spram[8'h10], 8'h00);
        check_eq("oam_off_00", spram[8'h00], 8'hF0);
        check_eq("oam_off_0f", spram[8'h0F], 8'hFF);

        fill_random(8'h07);
        run_dma(8'h07, 8'($urandom), 1'(($urandom)), 1'b1);

        cpu_wr(16'h4015, 8'h02);
        for (int n = 0; n < 6; n++) begin
            check_eq("foreign_no_halt", {cpu_halt, dma_active}, 0);
            @(negedge clk);
        end

        // Abort after 100 writes, then a clean transfer must still complete.
        fill_random(8'h05);
        cpu_wr(16'h2003, 8'h00);
        cpu_addr_in  = 16'h4014;
        cpu_data_in  = 8'h05;
        cpu_write_en = 1'b1;
        @(negedge clk);
        cpu_write_en = 1'b0;
        cpu_addr_in  = '0;
        cpu_data_in  = '0;
        begin
            int wr_cnt;
            wr_cnt = 0;
            for (int n = 0; n < 600 && wr_cnt < 100; n++) begin
                @(negedge clk);
                wr_cnt += int'(mem_write_en);
            end
            check_eq("abort_writes", wr_cnt, 100);
        end
        rst_n = 1'b0;
        #1;
        check_eq("abort_halt", cpu_halt, 0);
        check_eq("abort_active", dma_active, 0);
        check_eq("abort_addr", mem_addr, 0);
        check_eq("abort_data", mem_data_out, 0);
        check_eq("abort_strobes", {mem_write_en, mem_read_en, dma_done, dma_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_random(8'h06);
        run_dma(8'h06, 8'($urandom), 1'(($urandom)), 1'b0);

`ifdef OAM_DMA_PAGE_GUARD_EN
        cpu_wr(16'h4014, 8'h20);
        check_eq("guard_err_t1", dma_err, 1);
        check_eq("guard_halt_t1", cpu_halt, 0);
        @(negedge clk);
        check_eq("guard_err_pulse", dma_err, 0);
        for (int n = 0; n < 4; n++) begin
            check_eq("guard_no_halt", {cpu_halt, dma_active}, 0);
            @(negedge clk);
        end
`else
        fill_random(8'h20);
        run_dma(8'h20, 8'h00, 1'(($urandom)), 1'b0);
        check_eq("no_guard_err", dma_err, 0);
`endif

        fill_random(8'hFF);
        run_dma(8'hFF, 8'($urandom), 1'(($urandom)), 1'b0);

        for (int k = 0; k < 3; k++) begin
            pg = 8'($urandom_range(0, 31));
            fill_random(pg);
            run_dma(pg, 8'($urandom), 1'(($urandom)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
